// File: rtl/maze_solver_p_if.sv
// Handshake bundle for maze_solver_p: serial wall-map input and move-stream output.
interface maze_solver_p_if;
  logic       in_valid;
  logic       in;
  logic       out_valid;
  logic [1:0] out;
  logic       err;

  modport master (output in_valid, in, input out_valid, out, err);
  modport slave  (input in_valid, in, output out_valid, out, err);
endinterface

// File: rtl/maze_solver_p.sv
// DIMxDIM shortest-path maze solver: serial map load, parallel BFS flood from the goal, move trace.
// Optional feature macro MAZE_NOPATH_EN enables no-path detection with a one-cycle err report.
module maze_solver_p #(
  parameter int DIM = 17
) (
  input logic           clk,
  input logic           rst_n,
  maze_solver_p_if.slave bus
);
  localparam int RCW  = $clog2(DIM);
  localparam int IDXW = $clog2(DIM * DIM);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIM * DIM - 1);
  localparam logic [RCW-1:0]  LAST_RC  = RCW'(DIM - 1);

  function automatic logic [DIM*DIM-1:0] col_mask(input int col);
    logic [DIM*DIM-1:0] m;
    m = '0;
    for (int r = 0; r < DIM; r++) m[r*DIM+col] = 1'b1;
    return m;
  endfunction

  localparam logic [DIM*DIM-1:0] FIRST_COL = col_mask(0);
  localparam logic [DIM*DIM-1:0] LAST_COL  = col_mask(DIM - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FLOOD, S_TRACE, S_ERR} state_t;

  state_t                       state_q, state_d;
  logic [DIM-1:0][DIM-1:0]      map_q, map_d;
  logic [DIM-1:0][DIM-1:0]      vis_q, vis_d;
  logic [DIM-1:0][DIM-1:0][1:0] arrow_q, arrow_d;
  logic [IDXW-1:0]              idx_q, idx_d;
  logic [RCW-1:0]               row_q, row_d, col_q, col_d;
  logic [RCW-1:0]               pos_r_q, pos_r_d, pos_c_q, pos_c_d;

  logic [DIM*DIM-1:0]           vis_flat, nb_r, nb_d, nb_l, nb_u;
  logic [DIM-1:0][DIM-1:0]      new_vis;
  logic [DIM-1:0][DIM-1:0][1:0] new_arr;
  logic                         any_new;
  logic [1:0]                   mv;

  assign vis_flat = vis_q;
  assign mv       = arrow_q[pos_r_q][pos_c_q];

  // Wavefront: flat bit i = r*DIM+c, so row neighbours are +-1 and column neighbours are +-DIM.
  always_comb begin
    nb_r    = (vis_flat >> 1) & ~LAST_COL;
    nb_l    = (vis_flat << 1) & ~FIRST_COL;
    nb_d    = vis_flat >> DIM;
    nb_u    = vis_flat << DIM;
    new_vis = '0;
    new_arr = '0;
    for (int r = 0; r < DIM; r++) begin
      for (int c = 0; c < DIM; c++) begin
        if (map_q[r][c] && !vis_q[r][c]) begin
          if (nb_r[r*DIM+c]) begin
            new_vis[r][c] = 1'b1;
            new_arr[r][c] = 2'b00;
          end else if (nb_d[r*DIM+c]) begin
            new_vis[r][c] = 1'b1;
            new_arr[r][c] = 2'b01;
          end else if (nb_l[r*DIM+c]) begin
            new_vis[r][c] = 1'b1;
            new_arr[r][c] = 2'b10;
          end else if (nb_u[r*DIM+c]) begin
            new_vis[r][c] = 1'b1;
            new_arr[r][c] = 2'b11;
          end
        end
      end
    end
    any_new = |new_vis;
  end

  always_comb begin
    state_d = state_q;
    map_d   = map_q;
    vis_d   = vis_q;
    arrow_d = arrow_q;
    idx_d   = idx_q;
    row_d   = row_q;
    col_d   = col_q;
    pos_r_d = pos_r_q;
    pos_c_d = pos_c_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          map_d[0][0] = bus.in;
          idx_d       = IDXW'(1);
          row_d       = '0;
          col_d       = RCW'(1);
          state_d     = S_LOAD;
        end
      end
      S_LOAD: begin
        if (bus.in_valid) begin
          map_d[row_q][col_q] = bus.in;
          if (idx_q == LAST_IDX) begin
            idx_d                  = '0;
            row_d                  = '0;
            col_d                  = '0;
            vis_d                  = '0;
            vis_d[DIM-1][DIM-1]    = 1'b1;
            state_d                = S_FLOOD;
          end else begin
            idx_d = idx_q + IDXW'(1);
            if (col_q == LAST_RC) begin
              col_d = '0;
              row_d = row_q + RCW'(1);
            end else begin
              col_d = col_q + RCW'(1);
            end
          end
        end
      end
      S_FLOOD: begin
        vis_d = vis_q | new_vis;
        for (int r = 0; r < DIM; r++)
          for (int c = 0; c < DIM; c++)
            if (new_vis[r][c]) arrow_d[r][c] = new_arr[r][c];
        if (new_vis[0][0]) begin
          pos_r_d = '0;
          pos_c_d = '0;
          state_d = S_TRACE;
        end else if (!any_new) begin
`ifdef MAZE_NOPATH_EN
          state_d = S_ERR;
`else
          state_d = S_IDLE;
`endif
        end
      end
      S_TRACE: begin
        case (mv)
          2'b00:   pos_c_d = pos_c_q + RCW'(1);
          2'b01:   pos_r_d = pos_r_q + RCW'(1);
          2'b10:   pos_c_d = pos_c_q - RCW'(1);
          default: pos_r_d = pos_r_q - RCW'(1);
        endcase
        if (pos_r_d == LAST_RC && pos_c_d == LAST_RC) state_d = S_IDLE;
      end
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      map_q   <= '0;
      vis_q   <= '0;
      arrow_q <= '0;
      idx_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      pos_r_q <= '0;
      pos_c_q <= '0;
    end else begin
      state_q <= state_d;
      map_q   <= map_d;
      vis_q   <= vis_d;
      arrow_q <= arrow_d;
      idx_q   <= idx_d;
      row_q   <= row_d;
      col_q   <= col_d;
      pos_r_q <= pos_r_d;
      pos_c_q <= pos_c_d;
    end
  end

  // Outputs decode straight from the state register so an async reset clears them at once.
`ifdef MAZE_NOPATH_EN
  assign bus.out_valid = (state_q == S_TRACE) || (state_q == S_ERR);
  assign bus.err       = (state_q == S_ERR);
`else
  assign bus.out_valid = (state_q == S_TRACE);
  assign bus.err       = 1'b0;
`endif
  assign bus.out = (state_q == S_TRACE) ? mv : 2'b00;

endmodule
